// File: rtl/rf_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer.
// Holds the default geometry (depth, data width, register-select width),
// the packed {regsel, data} entry type used by the writeback stage and the
// register file, and a pointer-width helper.
package rf_write_buffer_pkg;

  localparam int WBUF_DEPTH = 4;
  localparam int WBUF_WIDTH = 16;
  localparam int WBUF_RSEL  = 3;

  typedef struct packed {
    logic [WBUF_RSEL-1:0]  regsel;
    logic [WBUF_WIDTH-1:0] data;
  } wbuf_entry_t;

  // Width of a queue pointer; never less than one bit.
  function automatic int wbuf_ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_wbuf_lookup.sv
// Combinational youngest-match search over the write-buffer entries.
// Ports:
//   regsels/datas : queue storage, indexed by physical slot
//   head, count   : oldest slot and number of pending entries
//   regsel        : register being looked up
//   hit           : some pending entry targets regsel
//   data          : value of the youngest such entry, 0 when no hit
module rf_wbuf_lookup
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  parameter int WIDTH = WBUF_WIDTH,
  parameter int RSEL  = WBUF_RSEL,
  parameter int PTR_W = wbuf_ptr_width(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic [RSEL-1:0]  regsels [DEPTH],
  input  logic [WIDTH-1:0] datas   [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [CNT_W-1:0] count,
  input  logic [RSEL-1:0]  regsel,
  output logic             hit,
  output logic [WIDTH-1:0] data
);

  // Walk entries oldest to youngest; a later match overrides an earlier one,
  // so the surviving value is the one nearest the tail.
  always_comb begin
    logic [PTR_W-1:0] idx_s;
    hit   = 1'b0;
    data  = '0;
    idx_s = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (regsels[idx_s] == regsel)) begin
        hit  = 1'b1;
        data = datas[idx_s];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/rf_write_buffer.sv
// In-order write buffer between the writeback stage and the register file.
// Requests are queued and drained one per cycle into the single write port
// whenever it is granted; pending values are visible through two lookup ports.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   wr_valid/wr_regsel/wr_data      : writeback request
//   wr_ready                        : queue not full
//   drain_en                        : register-file write port granted
//   write/writeregsel/writedata     : register-file write port
//   read1regsel/read2regsel         : lookup selects
//   read1hit/read1data/read2hit/... : youngest pending value per lookup
//   err                             : one-cycle pulse after a dropped request
module rf_write_buffer
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  parameter int WIDTH = WBUF_WIDTH,
  parameter int RSEL  = WBUF_RSEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [RSEL-1:0]  wr_regsel,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             drain_en,
  output logic             write,
  output logic [RSEL-1:0]  writeregsel,
  output logic [WIDTH-1:0] writedata,
  input  logic [RSEL-1:0]  read1regsel,
  input  logic [RSEL-1:0]  read2regsel,
  output logic             read1hit,
  output logic [WIDTH-1:0] read1data,
  output logic             read2hit,
  output logic [WIDTH-1:0] read2data,
  output logic             err
);

  localparam int PTR_W = wbuf_ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RSEL-1:0]  regsel_mem_r [DEPTH];
  logic [WIDTH-1:0] data_mem_r   [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             err_r;

  logic empty_s;
  logic full_s;
  logic enq_s;
  logic deq_s;

  assign empty_s  = (count_r == CNT_W'(0));
  assign full_s   = (count_r == CNT_W'(DEPTH));
  // Acceptance looks only at the registered count: a full queue refuses a
  // request even in a cycle where it is also draining.
  assign enq_s    = wr_valid && !full_s;
  assign deq_s    = drain_en && !empty_s;
  assign wr_ready = !full_s;
  assign err      = err_r;

  // Pointer, occupancy and drop-flag state; pointers wrap naturally since
  // DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      err_r <= wr_valid && full_s;
    end
  end

  // Entry storage; contents of unoccupied slots are don't-care because every
  // reader qualifies them with count.
  always_ff @(posedge clk) begin
    if (enq_s && !rst) begin
      regsel_mem_r[tail_r] <= wr_regsel;
      data_mem_r[tail_r]   <= wr_data;
    end
  end

  // Register-file write port: head entry, forced to zero while empty, and no
  // write is issued in a reset cycle.
  always_comb begin
    write = deq_s && !rst;
    if (empty_s) begin
      writeregsel = '0;
      writedata   = '0;
    end else begin
      writeregsel = regsel_mem_r[head_r];
      writedata   = data_mem_r[head_r];
    end
  end

  rf_wbuf_lookup #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .RSEL(RSEL), .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) u_lookup1 (
    .regsels(regsel_mem_r),
    .datas  (data_mem_r),
    .head   (head_r),
    .count  (count_r),
    .regsel (read1regsel),
    .hit    (read1hit),
    .data   (read1data)
  );

  rf_wbuf_lookup #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .RSEL(RSEL), .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) u_lookup2 (
    .regsels(regsel_mem_r),
    .datas  (data_mem_r),
    .head   (head_r),
    .count  (count_r),
    .regsel (read2regsel),
    .hit    (read2hit),
    .data   (read2data)
  );

endmodule
